counter_job_scheduler: RTL
==========================

// Module: counter_job_scheduler
// PURPOSE
//  Shares one counter datapath (ports start/ack/en/clear/done) between NUM_REQ requesters.
//  Round-robin arbitration picks one requester per job.
//  For each job, the block clears the datapath, enables it until done, then reports
//  completion to the owner and waits for that owner's ack.
//  Sits between requester logic (e.g. AXI-side register blocks) and the counter datapath.
// PARAMETERS
//  NUM_REQ      4     number of requesters, >=2
//  WDOG_CYCLES  64    COUNT-state cycle limit before a forced abort (used only with the watchdog macro)
// PORTS
//  clk          in   1        clock; all logic on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  req          in   NUM_REQ  level request per requester
//  ack          in   NUM_REQ  completion acknowledge per requester
//  grant        out  NUM_REQ  one-hot owner of the current job; 0 when idle
//  finished     out  NUM_REQ  one-hot completion flag; held until owner acks
//  err          out  1        current completion was a watchdog abort (valid with finished)
//  busy         out  1        high in any state other than IDLE
//  dp_clear     out  1        to datapath clear
//  dp_en        out  1        to datapath en
//  dp_done      in   1        from datapath done; meaningful only while dp_en=1
// BEHAVIOUR
//  Output style
//  - Moore. All outputs decode from registered state, owner index and err flag.
//  - No combinational path from any input to any output.
//  Reset
//  - state=IDLE; grant=0, finished=0, err=0, busy=0, dp_clear=0, dp_en=0.
//  - RR pointer=0. Any in-flight job is dropped silently.
//  States
//  - IDLE: no datapath control.
//    - If req!=0, the winner is the first set bit searching upward from the pointer, with wrap.
//    - Latch the owner index, then go to CLEAR.
//  - CLEAR: grant[owner]=1, dp_clear=1 for exactly 1 cycle, then go to COUNT.
//  - COUNT: grant[owner]=1, dp_en=1.
//    - On dp_done=1, go to REPORT on the next edge.
//  - REPORT: grant[owner]=1, finished[owner]=1, dp_en=0.
//    - On ack[owner]=1: go to IDLE, clear err, set pointer=(owner+1)%NUM_REQ.
//  Input handling
//  - ack bits of non-owners are ignored in all states.
//  - Any ack in IDLE/CLEAR/COUNT is ignored.
//  - dp_done is ignored outside COUNT.
//  - dp_en and dp_clear are never high in the same cycle.
//  Latency (req sampled at edge 0, datapath cnt starts at 0 in first COUNT cycle)
//  - grant high from cycle 1.
//  - dp_en high from cycle 2.
//  - dp_done at cycle 2+STOP.
//  - finished from cycle 3+STOP.
//  - Earliest next grant: 1 cycle after the ack edge (IDLE lasts >=1 cycle).
//  Boundaries
//  - req drop after grant: the job still runs to completion and finished is still presented.
//  - Owner's req still high in IDLE after its ack: treated as a new request at lowest RR priority.
//  - Simultaneous requests: arbitrated purely by the pointer; no starvation.
//    Each requester waits at most NUM_REQ-1 jobs.
//  - dp_done never arrives: without the watchdog the block stays in COUNT indefinitely (by design).
//  - Datapath cnt overshoots by one (STOP+1) after done. It is not cleaned up until the next CLEAR.
// CONFIGURATION
//  COUNTER_JOB_SCHED_WATCHDOG_EN defined:
//  - A $clog2(WDOG_CYCLES+1)-bit counter is zeroed on CLEAR and increments each COUNT cycle.
//  - If it reaches WDOG_CYCLES with dp_done=0, go to REPORT with err=1.
//  - err is held with finished until ack[owner].
//  - dp_done in the same cycle as the limit wins: normal completion, err=0.
//  COUNTER_JOB_SCHED_WATCHDOG_EN undefined:
//  - err is tied to 0, no watchdog counter exists, WDOG_CYCLES is unused.
// TESTING (datapath STOP=10, NUM_REQ=4, WDOG_CYCLES=64)
//  1. req=0001, ack 2 cycles after finished
//     -> grant=0001 at cycle 1; dp_clear 1 cycle; dp_en 11 cycles;
//        finished=0001 at cycle 13 and held until ack; then IDLE, busy=0.
//  2. req=1111 held, ack immediately on each finished
//     -> grant order 0001,0010,0100,1000,0001; no dp_en/dp_clear overlap.
//  3. Stray traffic during a job owned by 0010: ack=0001 and dp_done pulse while in CLEAR
//     -> both ignored; the job completes normally.
//  4. rst_n low mid-COUNT for 1 cycle, owner=0100
//     -> all outputs 0 asynchronously; next req=1100 grants 0100 (pointer=0).
//  5. Watchdog on: dp_done held at 0
//     -> REPORT after 64 COUNT cycles, finished=owner, err=1; ack clears err.
//  6. Watchdog on: dp_done at the 64th cycle -> err=0.
//     Watchdog off: same stimulus as test 5 -> no completion, err stays 0.

Source files
------------

// File: rtl/counter_job_scheduler.sv
// counter_job_scheduler
//   Shares one counter datapath between NUM_REQ requesters. A round-robin
//   arbiter picks an owner per job. Each job goes through four steps: clear
//   the datapath, enable it until done, report completion to the owner, and
//   wait for the owner's ack.
//   Outputs are a pure decode of registered state, owner index and err flag.
//   There is no combinational path from any input to any output.
//   Optional watchdog: define COUNTER_JOB_SCHED_WATCHDOG_EN. A job that stays
//   in COUNT for WDOG_CYCLES cycles is then aborted, and it completes with err=1.
module counter_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] finished,
  output logic               err,
  output logic               busy,
  output logic               dp_clear,
  output logic               dp_en,
  input  logic               dp_done
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_REPORT
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] owner_next;

`ifdef COUNTER_JOB_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic          err_q;
  logic [WW-1:0] wdog_cnt;
`endif

  // Round-robin search: first set req bit at or above ptr, wrapping around.
  // NOTE: every always_comb output is given a default before any branch, so no latch is inferred.
  always_comb begin
    int  j;
    logic found;
    winner = ptr;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        winner = IW'(j);
        found  = 1'b1;
      end
    end
  end

  // Pointer value that follows the current owner, with wrap.
  always_comb begin
    if (owner == IW'(NUM_REQ - 1)) owner_next = '0;
    else                           owner_next = owner + 1'b1;
  end

  // Job sequencer: IDLE -> CLEAR -> COUNT -> REPORT -> IDLE.
  // NOTE: state is updated with non-blocking assignments only. Every flop then samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner    <= '0;
      ptr      <= '0;
`ifdef COUNTER_JOB_SCHED_WATCHDOG_EN
      err_q    <= 1'b0;
      wdog_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner <= winner;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
`ifdef COUNTER_JOB_SCHED_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
          state <= S_COUNT;
        end
        S_COUNT: begin
          // dp_done wins over a watchdog limit reached in the same cycle.
          if (dp_done) begin
            state <= S_REPORT;
`ifdef COUNTER_JOB_SCHED_WATCHDOG_EN
          end else if (wdog_cnt == WW'(WDOG_CYCLES - 1)) begin
            state <= S_REPORT;
            err_q <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
`endif
          end
        end
        S_REPORT: begin
          if (ack[owner]) begin
            state <= S_IDLE;
            ptr   <= owner_next;
`ifdef COUNTER_JOB_SCHED_WATCHDOG_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state and owner.
  always_comb begin
    grant    = '0;
    finished = '0;
    if (state != S_IDLE)   grant[owner]    = 1'b1;
    if (state == S_REPORT) finished[owner] = 1'b1;
  end

  assign busy     = (state != S_IDLE);
  assign dp_clear = (state == S_CLEAR);
  assign dp_en    = (state == S_COUNT);

`ifdef COUNTER_JOB_SCHED_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
